// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Jump decoding is only used when FETCH_JUMP_EN is defined.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    function automatic logic is_jump(input logic [INSTR_W-1:0] w);
        return (w[31:26] == OP_J) || (w[31:26] == OP_JAL);
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Valid/ready instruction stream between the fetch stage (master) and the
// downstream instruction-class counter (slave).
interface instr_fetch_if;
    logic [fetch_pkg::INSTR_W-1:0] instruction;
    logic                          instr_valid;
    logic                          instr_ready;

    modport master (output instruction, output instr_valid, input instr_ready);
    modport slave  (input instruction, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_mem.sv
// DEPTH x 32 program memory: synchronous write, asynchronous read, no reset.
module instr_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// Streams a loaded program onto a registered valid/ready output.
// Build option: define FETCH_JUMP_EN to follow j/jal targets when fetching.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    instr_fetch_if.master      bus,
    output logic [ADDR_W-1:0]  pc,
    output logic [7:0]         issued,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);
    localparam logic [1:0] S_DONE  = 2'(DONE);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [1:0]         state;
    logic [ADDR_W:0]    len_q, fetched;
    logic [INSTR_W-1:0] word, instr_q;
    logic [ADDR_W-1:0]  next_pc;
    logic               valid_q, hs, load, mem_we;

    assign mem_we = load_en && (state == S_IDLE);

    instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (word)
    );

`ifdef FETCH_JUMP_EN
    assign next_pc = is_jump(word) ? word[ADDR_W-1:0] : ADDR_W'(pc + 1'b1);
`else
    assign next_pc = ADDR_W'(pc + 1'b1);
`endif

    assign hs   = valid_q && bus.instr_ready;
    // Output register reloads whenever it is empty or being drained this cycle.
    assign load = (state == S_RUN) && (!valid_q || bus.instr_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_q   <= '0;
            fetched <= '0;
            pc      <= '0;
            issued  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (hs) issued <= issued + 8'd1;
            case (state)
                S_IDLE: begin
                    if (start && prog_len != '0) begin
                        len_q   <= prog_len;
                        pc      <= '0;
                        fetched <= '0;
                        issued  <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        instr_q <= word;
                        valid_q <= 1'b1;
                        pc      <= next_pc;
                        fetched <= fetched + ONE;
                        if (fetched + ONE == len_q) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (hs) begin
                        valid_q <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, jump, reset, ignored inputs.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [2:0]  load_addr;
    logic [31:0] load_data;
    logic [3:0]  prog_len;
    logic        start;
    logic [2:0]  pc;
    logic [7:0]  issued;
    logic        busy, done;

    instr_fetch_if bus ();

    instr_fetch #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .bus       (bus),
        .pc        (pc),
        .issued    (issued),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] model [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [2:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
        model[a] = d;
    endtask

    initial begin
        logic [2:0] jaddr [4];
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; bus.instr_ready = 1'b0;
        model[0] = 32'h20043456; model[1] = 32'h2005FFFF; model[2] = 32'h00A43020;
        model[3] = 32'h24060001; model[4] = 32'h24070002; model[5] = 32'h00E63820;
        model[6] = 32'hAC070010; model[7] = 32'h8C080010;

        tick(); tick();
        check("rst_instr",  bus.instruction, 32'h0);
        check("rst_valid",  {31'b0, bus.instr_valid}, 32'h0);
        check("rst_pc",     {29'b0, pc}, 32'h0);
        check("rst_issued", {24'b0, issued}, 32'h0);
        check("rst_busy",   {31'b0, busy}, 32'h0);
        check("rst_done",   {31'b0, done}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) write_word(3'(i), model[i]);

        // start with zero length is ignored
        prog_len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_busy", {31'b0, busy}, 32'h0);

        // streaming, with an ignored load and start while busy
        prog_len = 4'd8; start = 1'b1; bus.instr_ready = 1'b1;
        tick();
        start = 1'b0;
        check("st_busy",  {31'b0, busy}, 32'h1);
        check("st_valid0", {31'b0, bus.instr_valid}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                load_en = 1'b1; load_addr = 3'd7; load_data = 32'hDEADBEEF;
                start = 1'b1; prog_len = 4'd2;
            end else begin
                load_en = 1'b0; start = 1'b0;
            end
            tick();
            check($sformatf("st_word%0d", i), bus.instruction, model[i]);
            check($sformatf("st_vld%0d", i), {31'b0, bus.instr_valid}, 32'h1);
            check($sformatf("st_iss%0d", i), {24'b0, issued}, i);
        end
        load_en = 1'b0; start = 1'b0;
        tick();
        check("st_done",    {31'b0, done}, 32'h1);
        check("st_vld_end", {31'b0, bus.instr_valid}, 32'h0);
        check("st_issued",  {24'b0, issued}, 32'd8);
        check("st_busy_end", {31'b0, busy}, 32'h0);
        tick();
        check("st_done_off", {31'b0, done}, 32'h0);
        check("st_iss_hold", {24'b0, issued}, 32'd8);

        // backpressure on word 2
        prog_len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("bp_word2", bus.instruction, 32'h00A43020);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), bus.instruction, 32'h00A43020);
            check($sformatf("bp_vld%0d", i), {31'b0, bus.instr_valid}, 32'h1);
            check($sformatf("bp_iss%0d", i), {24'b0, issued}, 32'd2);
        end
        bus.instr_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            tick();
            check($sformatf("bp_word%0d", i), bus.instruction, model[i]);
            check($sformatf("bp_iss%0d", i), {24'b0, issued}, i);
        end
        tick();
        check("bp_done",   {31'b0, done}, 32'h1);
        check("bp_issued", {24'b0, issued}, 32'd8);
        tick();

        // jump word; load and start in the same cycle (mem[0] rewritten)
        write_word(3'd2, 32'h08000005);
        load_en = 1'b1; load_addr = 3'd0; load_data = 32'h3C011234;
        prog_len = 4'd4; start = 1'b1;
        tick();
        model[0] = 32'h3C011234;
        load_en = 1'b0; start = 1'b0;
`ifdef FETCH_JUMP_EN
        jaddr[0] = 3'd0; jaddr[1] = 3'd1; jaddr[2] = 3'd2; jaddr[3] = 3'd5;
`else
        jaddr[0] = 3'd0; jaddr[1] = 3'd1; jaddr[2] = 3'd2; jaddr[3] = 3'd3;
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("jp_word%0d", i), bus.instruction, model[jaddr[i]]);
            if (i == 2) check("jp_pc", {29'b0, pc}, {29'b0, jaddr[3]});
        end
        tick();
        check("jp_done",   {31'b0, done}, 32'h1);
        check("jp_issued", {24'b0, issued}, 32'd4);
        tick();

        // reset after three handshakes
        prog_len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mr_iss3", {24'b0, issued}, 32'd3);
        rst_n = 1'b0;
        tick();
        check("mr_instr",  bus.instruction, 32'h0);
        check("mr_valid",  {31'b0, bus.instr_valid}, 32'h0);
        check("mr_pc",     {29'b0, pc}, 32'h0);
        check("mr_issued", {24'b0, issued}, 32'h0);
        check("mr_busy",   {31'b0, busy}, 32'h0);
        check("mr_done",   {31'b0, done}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("mr_done2", {31'b0, done}, 32'h0);
        prog_len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rs_word0", bus.instruction, model[0]);
        tick();
        check("rs_word1", bus.instruction, model[1]);
        tick();
        check("rs_done",   {31'b0, done}, 32'h1);
        check("rs_issued", {24'b0, issued}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that feeds the instruction-class counter. It holds a small program memory loaded over a write port. On `start` it streams the program, one 32-bit MIPS word per accepted handshake, onto the counter's `instruction` input using a registered valid/ready output. It reports progress through `pc`, `issued`, `busy` and a one-cycle `done` pulse.

## Interface
- `DEPTH`, 8, number of 32-bit words in program memory
- `ADDR_W`, 3, address width; `DEPTH == 2**ADDR_W`
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `load_en`  in  1  write `load_data` to `mem[load_addr]`; honoured only in IDLE
- `load_addr`  in  ADDR_W  program memory write address
- `load_data`  in  32  program word
- `prog_len`  in  ADDR_W+1  words to fetch, 1..DEPTH; sampled on `start`
- `start`  in  1  begin run; honoured only in IDLE with `prog_len != 0`
- `instruction`  out  32  current word to the downstream counter
- `instr_valid`  out  1  `instruction` is valid
- `instr_ready`  in  1  downstream accepts the word this cycle
- `pc`  out  ADDR_W  address of the next word to fetch
- `issued`  out  8  handshakes completed in the current or last run
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at the end of a run

## Operation
- The state machine has four states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `load_en` writes memory.
  - On `start` with `prog_len != 0`: latch `prog_len` into `len_q`, clear `pc`, internal `fetched` and `issued`, then go to RUN.
  - `start` with `prog_len == 0` is ignored.
- **RUN**
  - The output register loads when `!instr_valid || instr_ready`. It then takes `instruction <= mem[pc]`, sets `instr_valid <= 1`, sets `pc <= next_pc`, and increments `fetched`.
  - When the load brings `fetched` to `len_q`, go to DRAIN.
- **DRAIN**
  - Hold `instruction` until `instr_valid && instr_ready`.
  - Then clear `instr_valid` and go to DONE.
- **DONE**
  - `done = 1` for exactly one cycle, then go to IDLE.
- `issued` increments on every `instr_valid && instr_ready`, in any state. It holds its value after the run.
- `next_pc = pc + 1`, wrapping modulo DEPTH. A jump changes this only when `FETCH_JUMP_EN` is set (see Configuration).
- `load_en`, `start` and `prog_len` are ignored outside IDLE.
- **Simultaneous events**
  - `load_en` and `start` in the same IDLE cycle: the write lands and is visible to the first fetch.
  - A handshake and a reload in the same cycle give seamless back-to-back words.
- While `instr_valid && !instr_ready`, `instruction` holds stable.
- Memory contents are not reset.

## Timing
- Reset values: `instruction = 0`, `instr_valid = 0`, `pc = 0`, `issued = 0`, `busy = 0`, `done = 0`, state IDLE.
- `start` sampled at edge k: `busy` is high after edge k. The first word is valid after edge k+1 (2-cycle latency).
- With `instr_ready` held high, throughput is one word per cycle.
- Final handshake at edge m: `instr_valid` is low and `done` is high after edge m. `done` is low again after edge m+1.
- `rst_n` low mid-run: at the next edge all outputs take their reset values and no `done` is produced. A new `start` restarts from word 0.

## Configuration
- Macro: `FETCH_JUMP_EN`.
- **Defined:** when the loaded word's opcode `[31:26]` is `6'h02` (j) or `6'h03` (jal), `next_pc = word[ADDR_W-1:0]`.
  - Termination is still by `fetched == len_q`, so loops always end.
- **Undefined:** `next_pc = pc + 1` always. Jump words pass through unmodified.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - `INSTR_W = 32`;
  - `OP_J = 6'h02` and `OP_JAL = 6'h03`.
- Sub-module `instr_mem`: a DEPTH x 32 array with synchronous write and asynchronous read.

## Test plan
- **Streaming:** load the 8-word program, starting with `0x20043456` (addi $4,$0,0x3456), `0x2005FFFF` and `0x00A43020`, then `prog_len = 8`, `start`, `instr_ready = 1`.
  - Required: 8 words in address order on 8 consecutive cycles.
  - Required: `issued = 8`, then a single `done` pulse, `busy` low afterwards.
- **Backpressure:** drop `instr_ready` for 3 cycles while `0x00A43020` is presented.
  - Required: that word holds stable and `issued` does not advance.
  - Required: the stream resumes with no word lost or duplicated.
- **Jump:** `mem[2] = 0x08000005`, `prog_len = 4`.
  - With `FETCH_JUMP_EN`: addresses 0, 1, 2, 5.
  - Without it: addresses 0, 1, 2, 3.
- **Reset mid-run:** drop `rst_n` after 3 handshakes.
  - Required: all outputs are 0 next cycle and no `done` appears.
  - Required: a new `start` re-streams from `mem[0]`.
- **Ignored inputs:**
  - `start` with `prog_len = 0`: `busy` stays 0.
  - `load_en` while `busy`: memory unchanged, verified on a later run.
  - `start` while `busy`: ignored.
